// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rc4_pkg
// Brief    : Shared types and constants for the rc4 keystream consumer path.
// Revision : 1.0
// ============================================================================
package rc4_pkg;

    localparam int RC4_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rc4_state_t;

    typedef logic [7:0] rc4_byte_t;

endpackage
`default_nettype wire

// File: rtl/rc4_ks_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rc4_ks_fifo
// Brief    : Small synchronous keystream prefetch FIFO with a registered head.
// Revision : 1.0
// ============================================================================
module rc4_ks_fifo
    import rc4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  rc4_byte_t wdata,
    output rc4_byte_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    rc4_byte_t       r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;

    // Requests against a full/empty FIFO are dropped rather than corrupting state.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == c_DEPTH);
    assign empty  = (r_count == '0);
    assign rdata  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rc4_stream_xor.sv
`default_nettype none
// ============================================================================
// Module   : rc4_stream_xor
// Brief    : Buffers rc4 keystream bytes and XORs them onto a data byte stream.
// Revision : 1.0
// ============================================================================
module rc4_stream_xor
    import rc4_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = RC4_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             ks_valid,
    input  logic [7:0]       ks_byte,
    output logic             ks_ready,
    input  logic             din_valid,
    input  logic [7:0]       din,
    output logic             din_ready,
    output logic             dout_valid,
    output logic [7:0]       dout,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] byte_cnt
);

    localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

    rc4_state_t       r_state;
    rc4_state_t       w_state_nxt;
    logic [LEN_W-1:0] r_fetch_left;
    logic [LEN_W-1:0] r_data_left;
    logic [LEN_W-1:0] r_byte_cnt;
    rc4_byte_t        r_dout;
    logic             r_dout_valid;
    rc4_byte_t        w_ks_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_ks_hs;
    logic             w_din_hs;
    logic             w_dout_hs;

    rc4_ks_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_ks_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_ks_hs),
        .pop   (w_din_hs),
        .wdata (ks_byte),
        .rdata (w_ks_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Fetch is capped at msg_len so the rc4 core never runs ahead of the message.
    assign ks_ready  = (r_state == RUN) && !w_fifo_full && (r_fetch_left != '0);
    assign din_ready = (r_state == RUN) && !w_fifo_empty && (r_data_left != '0)
                       && (!r_dout_valid || dout_ready);

    assign w_ks_hs   = ks_valid && ks_ready;
    assign w_din_hs  = din_valid && din_ready;
    assign w_dout_hs = r_dout_valid && dout_ready;

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign byte_cnt   = r_byte_cnt;
    assign busy       = (r_state == RUN) || (r_state == DRAIN);
    assign done       = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (msg_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_din_hs && (r_data_left == c_ONE)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_dout_valid || dout_ready) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_left <= '0;
            r_data_left  <= '0;
            r_byte_cnt   <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_fetch_left <= msg_len;
                r_data_left  <= msg_len;
                r_byte_cnt   <= '0;
            end else begin
                if (w_ks_hs) begin
                    r_fetch_left <= r_fetch_left - c_ONE;
                end
                if (w_din_hs) begin
                    r_data_left <= r_data_left - c_ONE;
                end
                if (w_dout_hs) begin
                    r_byte_cnt <= r_byte_cnt + c_ONE;
                end
            end
            // A new byte may load in the same cycle the old one is taken.
            if (w_din_hs) begin
                r_dout       <= din ^ w_ks_head;
                r_dout_valid <= 1'b1;
            end else if (dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc4_stream_xor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rc4_stream_xor
// Brief    : Directed scoreboard bench for rc4_stream_xor.
// Revision : 1.0
// ============================================================================
module tb_rc4_stream_xor;

    localparam int c_DEPTH = 4;
    localparam int c_LEN_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [c_LEN_W-1:0] msg_len = '0;
    logic               ks_valid = 1'b0;
    logic [7:0]         ks_byte = '0;
    logic               ks_ready;
    logic               din_valid = 1'b0;
    logic [7:0]         din = '0;
    logic               din_ready;
    logic               dout_valid;
    logic [7:0]         dout;
    logic               dout_ready = 1'b1;
    logic               busy;
    logic               done;
    logic [c_LEN_W-1:0] byte_cnt;

    rc4_stream_xor #(
        .FIFO_DEPTH (c_DEPTH),
        .LEN_W      (c_LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .msg_len    (msg_len),
        .ks_valid   (ks_valid),
        .ks_byte    (ks_byte),
        .ks_ready   (ks_ready),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] ks_arr  [16];
    logic [7:0] din_arr [16];
    logic [7:0] sb [$];
    logic [7:0] out_log [$];
    int         ks_hs;
    int         done_cnt;
    int         done_cyc;
    int         din_start;
    int         stall_lo;
    int         stall_hi;
    int         check_cyc;
    bit         ks_ready_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_knobs(input int d_start, input int s_lo, input int s_hi, input int c_cyc);
        din_start = d_start;
        stall_lo  = s_lo;
        stall_hi  = s_hi;
        check_cyc = c_cyc;
    endtask

    // Drives one full message; the keystream source is always willing and
    // expected outputs are din[i] ^ ks[i] queued at each din handshake.
    task automatic run_msg(input int len, input string tag);
        int         cyc = 0;
        int         ks_i = 0;
        int         din_i = 0;
        bit         hold = 1'b0;
        logic [7:0] prev_dout = '0;
        logic [7:0] e;
        sb.delete();
        out_log.delete();
        ks_hs = 0;
        done_cnt = 0;
        done_cyc = -1;
        ks_ready_seen = 1'b0;
        while (cyc < 300) begin
            @(posedge clk); #1;
            start      = (cyc == 0);
            msg_len    = c_LEN_W'(len);
            ks_valid   = (cyc > 0);
            ks_byte    = ks_arr[ks_i % 16];
            din_valid  = (din_i < len) && (cyc >= din_start);
            din        = din_arr[din_i % 16];
            dout_ready = !((cyc >= stall_lo) && (cyc < stall_hi));
            @(negedge clk);
            if (hold) begin
                chk({tag, "_hold"}, {23'd0, dout_valid, dout}, {23'd0, 1'b1, prev_dout});
            end
            hold = dout_valid && !dout_ready;
            if (hold) begin
                prev_dout = dout;
                chk({tag, "_stall_din_ready"}, 32'(din_ready), 32'd0);
            end
            if (cyc == check_cyc) begin
                chk({tag, "_ks_ready_full"}, 32'(ks_ready), 32'd0);
                chk({tag, "_ks_prefetch"}, 32'(ks_hs), 32'(c_DEPTH));
            end
            if (ks_ready) ks_ready_seen = 1'b1;
            if (ks_valid && ks_ready) begin
                ks_i++;
                ks_hs++;
            end
            if (din_valid && din_ready) begin
                sb.push_back(din ^ ks_arr[din_i % 16]);
                din_i++;
            end
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    chk({tag, "_extra_out"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, "_dout"}, 32'(dout), 32'(e));
                    out_log.push_back(dout);
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(len));
                    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                end
            end
            cyc++;
            if ((done_cyc >= 0) && (cyc > done_cyc + 2)) break;
        end
        chk({tag, "_timeout"}, 32'(done_cyc >= 0), 32'd1);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_ks_handshakes"}, 32'(ks_hs), 32'(len));
        chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
        if (len == 0) begin
            chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd1);
            chk({tag, "_ks_ready_seen"}, 32'(ks_ready_seen), 32'd0);
        end
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
    endtask

    initial begin
        set_knobs(0, -1, -1, -1);
        #1;
        chk("reset_outputs",
            {3'd0, ks_ready, din_ready, dout_valid, dout, busy, done, byte_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic encrypt
        ks_arr[0] = 8'h11; ks_arr[1] = 8'h22; ks_arr[2] = 8'h33;
        din_arr[0] = 8'h41; din_arr[1] = 8'h42; din_arr[2] = 8'h43;
        run_msg(3, "enc");
        chk("enc_size", 32'(out_log.size()), 32'd3);
        chk("enc_b0", 32'(out_log[0]), 32'h50);
        chk("enc_b1", 32'(out_log[1]), 32'h60);
        chk("enc_b2", 32'(out_log[2]), 32'h70);

        // Round trip with the same keystream
        din_arr[0] = 8'h50; din_arr[1] = 8'h60; din_arr[2] = 8'h70;
        run_msg(3, "dec");
        chk("dec_b0", 32'(out_log[0]), 32'h41);
        chk("dec_b1", 32'(out_log[1]), 32'h42);
        chk("dec_b2", 32'(out_log[2]), 32'h43);

        // Prefetch limit: data held off, FIFO fills, total fetch bounded by msg_len
        for (int i = 0; i < 16; i++) begin
            ks_arr[i]  = 8'(8'h80 + i * 7);
            din_arr[i] = 8'(8'h05 + i * 13);
        end
        set_knobs(8, -1, -1, 7);
        run_msg(10, "prefetch");

        // Output backpressure for 5 cycles mid-message
        set_knobs(0, 6, 11, -1);
        run_msg(8, "stall");

        // Zero-length message
        set_knobs(0, -1, -1, -1);
        run_msg(0, "zero");
        chk("zero_byte_cnt", 32'(byte_cnt), 32'd0);

        // Reset mid-message with 2 keystream bytes buffered
        @(posedge clk); #1;
        start = 1'b1; msg_len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0; ks_valid = 1'b1; ks_byte = 8'hAA;
        @(posedge clk); #1;
        ks_byte = 8'hBB;
        @(posedge clk); #1;
        ks_valid = 1'b0;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs",
            {3'd0, ks_ready, din_ready, dout_valid, dout, busy, done, byte_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ks_arr[0] = 8'h3C; ks_arr[1] = 8'hC3;
        din_arr[0] = 8'h01; din_arr[1] = 8'h02;
        run_msg(2, "after_reset");
        chk("after_reset_b0", 32'(out_log[0]), 32'h3D);
        chk("after_reset_b1", 32'(out_log[1]), 32'hC1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
